// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div4_seq_sub_n.sv
// Ripple subtractor a - b built as a + ~b + 1 from full-adder cells.
// c_out = 1 means no borrow (a >= b).
module fa (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module sub_n #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             c_out
);
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa u_fa (
            .a     (a[i]),
            .b     (~b[i]),
            .c_in  (carry[i]),
            .sum   (diff[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out = carry[WIDTH];
endmodule

// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done
// handshake, divide-by-zero reported through div0 without entering CALC.
module div4_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div0
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dq;      // dividend shifts out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   p;       // partial remainder; always < B, so its extra top bit is never stored
    logic [WIDTH:0]     t;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   p_next;
    logic               no_borrow;
    logic               accept;
    logic               diff_msb_unused;

    assign t = {p, dq[WIDTH-1]};

    sub_n #(.WIDTH(WIDTH + 1)) u_sub (
        .a     (t),
        .b     ({1'b0, b_reg}),
        .diff  (diff),
        .c_out (no_borrow)
    );

    // When the difference is selected it is below B, so its MSB is always 0.
    assign diff_msb_unused = diff[WIDTH];
    assign p_next          = no_borrow ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    assign accept          = start && ((state == IDLE) || (state == DONE));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) state_next = (B == '0) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            Q    <= '0;
            R    <= '0;
            div0 <= 1'b0;
        end else if (accept) begin
            cnt  <= CNT_W'(WIDTH - 1);
            div0 <= (B == '0);
            if (B == '0) begin
                Q <= '1;
                R <= A;
            end
        end else if (state == CALC) begin
            if (cnt == '0) begin
                Q <= {dq[WIDTH-2:0], no_borrow};
                R <= p_next;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // NOTE: datapath registers are not reset; they are always loaded on an accepted start before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            dq    <= A;
            b_reg <= B;
            p     <= '0;
        end else if (state == CALC) begin
            dq <= {dq[WIDTH-2:0], no_borrow};
            p  <= p_next;
        end
    end

endmodule
